move_sched: RTL and testbench

Move scheduler between the debounced key-pulse outputs of the input controller and the Tetris board-update logic. It latches single-cycle move requests (left, right, rotate, soft drop) and an internally generated gravity tick, and arbitrates them by fixed priority. It issues one move at a time to the board over a valid/ready handshake. It also owns pause state and the level-dependent gravity period.

---
 rtl/move_sched_if.sv | 9 +
 rtl/move_sched.sv | 158 +++++++++++++++
 tb/tb_move_sched.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/move_sched_if.sv
// Move handshake between the scheduler (master) and the board-update logic (slave).
interface move_if;
   logic       mv_valid;
   logic [2:0] mv_op;
   logic       mv_ready;

   modport master (output mv_valid, output mv_op, input mv_ready);
   modport slave  (input mv_valid, input mv_op, output mv_ready);
endinterface

// File: rtl/move_sched.sv
// Tetris move scheduler: latches key/gravity requests, arbitrates by fixed priority, owns pause.
// Optional feature: define SOFT_DROP_EN to enable soft-drop requests from k_down.
module move_sched #(
   parameter int GRAV_BASE = 50_000_000,
   parameter int GRAV_STEP = 3_000_000,
   parameter int GRAV_MIN  = 5_000_000,
   parameter int CW        = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       k_left,
   input  logic       k_right,
   input  logic       k_rot,
   input  logic       k_down,
   input  logic       pause_tgl,
   input  logic       grav_rst,
   input  logic [3:0] level,
   move_if.master     mv,
   output logic       paused
);

   localparam int PW = CW + 4;
   localparam logic [PW-1:0] BASE_C = PW'(GRAV_BASE);
   localparam logic [PW-1:0] MIN_C  = PW'(GRAV_MIN);
   localparam logic [PW-1:0] SPAN_C = BASE_C - MIN_C;

   localparam logic [2:0] OP_LEFT  = 3'd0;
   localparam logic [2:0] OP_RIGHT = 3'd1;
   localparam logic [2:0] OP_ROT   = 3'd2;
   localparam logic [2:0] OP_SOFT  = 3'd3;
   localparam logic [2:0] OP_GRAV  = 3'd4;

   typedef enum logic [1:0] {IDLE, ISSUE, PAUSED} state_t;

   // Clamp is decided before subtracting so high levels can never wrap the period.
   function automatic logic [CW-1:0] grav_period(input logic [3:0] lvl);
      logic [PW-1:0] dec;
      logic [PW-1:0] per;
      dec = PW'(lvl) * PW'(GRAV_STEP);
      if (dec >= SPAN_C) per = MIN_C;
      else               per = BASE_C - dec;
      return CW'(per - PW'(1));
   endfunction

   function automatic logic [2:0] pick_op(input logic [4:0] p);
      if      (p[OP_ROT])   return OP_ROT;
      else if (p[OP_LEFT])  return OP_LEFT;
      else if (p[OP_RIGHT]) return OP_RIGHT;
      else if (p[OP_SOFT])  return OP_SOFT;
      else                  return OP_GRAV;
   endfunction

   state_t        state_q, state_d;
   logic [4:0]    pend_q, pend_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pflag_q, pflag_d;
   logic          valid_q, valid_d;
   logic [2:0]    op_q, op_d;
   logic          paused_q, paused_d;

   logic          soft_w;
   logic [CW-1:0] reload_w;
   logic [3:0]    keys_w;
   logic [4:0]    clr_w;
   logic          grav_hit_w;

`ifdef SOFT_DROP_EN
   assign soft_w = k_down;
`else
   logic  soft_unused;
   assign soft_unused = k_down;
   assign soft_w      = 1'b0;
`endif

   assign reload_w    = grav_period(level);
   assign keys_w      = (state_q == PAUSED) ? 4'b0 : {soft_w, k_rot, k_right, k_left};
   assign mv.mv_valid = valid_q;
   assign mv.mv_op    = op_q;
   assign paused      = paused_q;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      op_d       = op_q;
      pflag_d    = pflag_q;
      paused_d   = paused_q;
      clr_w      = 5'b0;
      cnt_d      = cnt_q;
      grav_hit_w = 1'b0;

      // Gravity counter: grav_rst beats expiry; frozen while paused.
      if (grav_rst) begin
         cnt_d = reload_w;
      end else if (state_q != PAUSED) begin
         if (cnt_q == '0) begin
            cnt_d      = reload_w;
            grav_hit_w = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            pflag_d = 1'b0;
            if (pflag_q ^ pause_tgl) begin
               state_d  = PAUSED;
               paused_d = 1'b1;
               clr_w    = 5'b11111;
            end else if (|pend_q) begin
               op_d    = pick_op(pend_q);
               valid_d = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (pause_tgl) pflag_d = ~pflag_q;
            if (mv.mv_ready) begin
               clr_w   = 5'b00001 << op_q;
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         PAUSED: begin
            if (pause_tgl) begin
               state_d  = IDLE;
               paused_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (grav_rst) clr_w[OP_GRAV] = 1'b1;
      // New requests win over a same-edge clear.
      pend_d = (pend_q & ~clr_w) | {grav_hit_w, keys_w};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pend_q   <= 5'b0;
         cnt_q    <= CW'(GRAV_BASE - 1);
         pflag_q  <= 1'b0;
         valid_q  <= 1'b0;
         op_q     <= 3'd0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         cnt_q    <= cnt_d;
         pflag_q  <= pflag_d;
         valid_q  <= valid_d;
         op_q     <= op_d;
         paused_q <= paused_d;
      end
   end

endmodule

// File: tb/tb_move_sched.sv
// Directed bench for move_sched: per-edge vector table plus hand sequences for gravity, stalls and pause.
module tb_move_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       k_left = 1'b0, k_right = 1'b0, k_rot = 1'b0, k_down = 1'b0;
   logic       pause_tgl = 1'b0, grav_rst = 1'b0;
   logic [3:0] level = 4'd0;
   int         checks = 0;
   int         errors = 0;

   move_if mvif ();

   move_sched #(.GRAV_BASE(20), .GRAV_STEP(3), .GRAV_MIN(8), .CW(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .k_left    (k_left),
      .k_right   (k_right),
      .k_rot     (k_rot),
      .k_down    (k_down),
      .pause_tgl (pause_tgl),
      .grav_rst  (grav_rst),
      .level     (level),
      .mv        (mvif),
      .paused    ()
   );

   wire paused_w = dut.paused;

   always #5 clk = ~clk;

   typedef struct {
      logic       l, r, rot, dn, pt, gr, rdy;
      logic       ev;
      logic [2:0] eop;
      logic       ep;
   } vec_t;

   vec_t vt[23];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input logic l, r, rot, dn, pt, gr, rdy);
      k_left = l; k_right = r; k_rot = rot; k_down = dn;
      pause_tgl = pt; grav_rst = gr; mvif.mv_ready = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic l, r, rot, dn, pt, gr, rdy);
      drive(l, r, rot, dn, pt, gr, rdy);
      tick();
   endtask

   // Idle with ready high until the next move appears; n = steps taken, -1 on timeout.
   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         step(0, 0, 0, 0, 0, 0, 1);
         if (mvif.mv_valid) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int bad;
      int lefts;
      int exp_per[7];

      vt[0]  = '{0,0,0,0,0,1,1, 0,3'd0,0};
      vt[1]  = '{0,0,1,0,0,0,1, 0,3'd0,0};
      vt[2]  = '{0,0,0,0,0,0,1, 1,3'd2,0};
      vt[3]  = '{0,0,0,0,0,0,1, 0,3'd2,0};
      vt[4]  = '{0,0,0,0,0,0,1, 0,3'd2,0};
      vt[5]  = '{1,1,1,0,0,0,1, 0,3'd2,0};
      vt[6]  = '{0,0,0,0,0,0,1, 1,3'd2,0};
      vt[7]  = '{0,0,0,0,0,0,1, 0,3'd2,0};
      vt[8]  = '{0,0,0,0,0,0,1, 1,3'd0,0};
      vt[9]  = '{0,0,0,0,0,0,1, 0,3'd0,0};
      vt[10] = '{0,0,0,0,0,0,1, 1,3'd1,0};
      vt[11] = '{0,0,0,0,0,0,1, 0,3'd1,0};
      vt[12] = '{0,0,0,0,0,0,1, 0,3'd1,0};
      vt[13] = '{1,0,0,0,0,1,1, 0,3'd1,0};
      vt[14] = '{0,0,0,0,0,0,0, 1,3'd0,0};
      vt[15] = '{0,0,0,0,1,0,0, 1,3'd0,0};
      vt[16] = '{0,0,0,0,0,0,1, 0,3'd0,0};
      vt[17] = '{0,0,0,0,0,0,1, 0,3'd0,1};
      vt[18] = '{0,0,1,0,0,0,1, 0,3'd0,1};
      vt[19] = '{1,0,0,0,0,0,1, 0,3'd0,1};
      vt[20] = '{0,0,0,0,0,0,1, 0,3'd0,1};
      vt[21] = '{0,0,0,0,1,0,1, 0,3'd0,0};
      vt[22] = '{0,0,0,0,0,0,1, 0,3'd0,0};

      mvif.mv_ready = 1'b0;
      tick(); tick();
      check("reset valid", int'(mvif.mv_valid), 0);
      check("reset op", int'(mvif.mv_op), 0);
      check("reset paused", int'(paused_w), 0);
      #2 rst_n = 1'b1;
      tick();

      for (int i = 0; i < 23; i++) begin
         step(vt[i].l, vt[i].r, vt[i].rot, vt[i].dn, vt[i].pt, vt[i].gr, vt[i].rdy);
         check($sformatf("row%0d valid", i), int'(mvif.mv_valid), int'(vt[i].ev));
         check($sformatf("row%0d op", i), int'(mvif.mv_op), int'(vt[i].eop));
         check($sformatf("row%0d paused", i), int'(paused_w), int'(vt[i].ep));
      end

      // Counter was frozen at 15 while paused, so the first tick lands 16 steps after resume.
      wait_valid(n);
      check("grav resume latency", n, 16);
      check("grav resume op", int'(mvif.mv_op), 4);

      exp_per = '{20, 20, 8, 8, 8, 8, 11};
      for (int k = 0; k < 7; k++) begin
         if (k == 1) level = 4'd4;
         if (k == 3) level = 4'd15;
         if (k == 5) level = 4'd3;
         wait_valid(n);
         check($sformatf("grav period %0d", k), n, exp_per[k]);
         check($sformatf("grav op %0d", k), int'(mvif.mv_op), 4);
      end
      level = 4'd0;
      step(0, 0, 0, 0, 0, 0, 1);

      // Stalled LEFT with extra pulses coalescing.
      step(1, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("stall first valid", int'(mvif.mv_valid), 1);
      check("stall first op", int'(mvif.mv_op), 0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step((i % 10) == 5, 0, 0, 0, 0, 0, 0);
         if (!mvif.mv_valid || mvif.mv_op != 3'd0) bad++;
      end
      check("stall hold", bad, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("stall release", int'(mvif.mv_valid), 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("after stall valid", int'(mvif.mv_valid), 1);
      check("after stall op", int'(mvif.mv_op), 4);
      lefts = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, 0, 0, 0, 0, 0, 1);
         if (mvif.mv_valid && mvif.mv_op == 3'd0) lefts++;
      end
      check("no extra left", lefts, 0);

      // Two pause toggles during one ISSUE cancel each other.
      step(1, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("cancel issue", int'(mvif.mv_valid), 1);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("cancel done", int'(mvif.mv_valid), 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("cancel paused a", int'(paused_w), 0);
      step(0, 0, 0, 0, 0, 0, 1);
      check("cancel paused b", int'(paused_w), 0);
      check("cancel no move", int'(mvif.mv_valid), 0);

      // Soft drop depends on build configuration.
      step(0, 0, 0, 1, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 1);
`ifdef SOFT_DROP_EN
      check("soft valid", int'(mvif.mv_valid), 1);
      check("soft op", int'(mvif.mv_op), 3);
`else
      check("soft ignored", int'(mvif.mv_valid), 0);
`endif
      step(0, 0, 0, 0, 0, 0, 1);
      check("soft after", int'(mvif.mv_valid), 0);

      // Asynchronous reset while a move is outstanding.
      step(0, 1, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("pre-reset valid", int'(mvif.mv_valid), 1);
      check("pre-reset op", int'(mvif.mv_op), 1);
      rst_n = 1'b0;
      #1;
      check("async reset valid", int'(mvif.mv_valid), 0);
      check("async reset op", int'(mvif.mv_op), 0);
      #1 rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      check("post-reset idle", int'(mvif.mv_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
